// File: rtl/clk_sw_pkg.sv
// Shared types and defaults for the clock-switch sequencer.
package clk_sw_pkg;

    typedef enum logic [2:0] {
        StOff,
        StOn,
        StDrain,
        StSwitch,
        StSettle
    } clk_sw_state_e;

    localparam int unsigned DefOffCycles    = 4;
    localparam int unsigned DefSettleCycles = 8;
    localparam int unsigned DefRstSel       = 0;

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/clk_sw_cnt.sv
// Loadable down-counter; expire_o flags the last cycle of a timed phase (count == 1).
module clk_sw_cnt #(
    parameter int unsigned CNT_W = 4
) (
    input  logic             clk_i,
    input  logic             arst_ni,
    input  logic             load_i,
    input  logic [CNT_W-1:0] load_val_i,
    output logic             expire_o
);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Load on phase entry, otherwise count down and rest at zero.
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    // Counter register.
    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expire_o = (cnt_q == CNT_W'(1));

endmodule

// File: rtl/clk_switch_ctrl.sv
// Glitch-free clock source switch sequencer: gate off, drain, switch select,
// settle, gate back on. Runs on the always-on reference clock.
// Optional: define CLK_SW_ERR_EN to reject out-of-range selects and add err_o;
// otherwise out-of-range selects are clamped to NUM_SRC-1.
module clk_switch_ctrl
    import clk_sw_pkg::*;
#(
    parameter int unsigned NUM_SRC       = 4,
    parameter int unsigned SEL_W         = 2,
    parameter int unsigned OFF_CYCLES    = DefOffCycles,
    parameter int unsigned SETTLE_CYCLES = DefSettleCycles,
    parameter int unsigned RST_SEL       = DefRstSel
) (
    input  logic             clk_i,
    input  logic             arst_ni,
    input  logic             en_req_i,
    input  logic             sel_valid_i,
    input  logic [SEL_W-1:0] sel_i,
    output logic             sel_ready_o,
    output logic [SEL_W-1:0] sel_o,
    output logic             en_o,
    output logic             busy_o,
    output logic             done_o
`ifdef CLK_SW_ERR_EN
    ,
    output logic             err_o
`endif
);

    localparam int unsigned      CNT_W    = $clog2(max_u(OFF_CYCLES, SETTLE_CYCLES) + 1);
    localparam logic [SEL_W-1:0] MAX_SEL  = SEL_W'(NUM_SRC - 1);
    localparam logic [SEL_W-1:0] RST_SELV = SEL_W'(RST_SEL);

    clk_sw_state_e    state_q, state_d;
    logic [SEL_W-1:0] sel_q, sel_d;
    logic [SEL_W-1:0] pend_q, pend_d;
    logic             sw_q, sw_d;
    logic             en_q, en_d;
    logic             done_q, done_d;

    logic             accept, sel_oor, req_take, req_new, req_same;
    logic [SEL_W-1:0] sel_req;
    logic             cnt_load, cnt_exp;
    logic [CNT_W-1:0] cnt_val;

    assign accept = sel_valid_i & sel_ready_o;

    // Only an index space wider than NUM_SRC can hold out-of-range values.
    if (NUM_SRC < (2 ** SEL_W)) begin : g_oor
        assign sel_oor = (sel_i > MAX_SEL);
    end else begin : g_no_oor
        assign sel_oor = 1'b0;
    end

`ifdef CLK_SW_ERR_EN
    logic err_q;
    assign req_take = accept & ~sel_oor;
    assign sel_req  = sel_i;
`else
    assign req_take = accept;
    assign sel_req  = sel_oor ? MAX_SEL : sel_i;
`endif

    assign req_new  = req_take && (sel_req != sel_q);
    assign req_same = req_take && (sel_req == sel_q);

    // Next-state, select and completion decode.
    always_comb begin
        state_d = state_q;
        sw_d    = sw_q;
        pend_d  = pend_q;
        sel_d   = sel_q;
        done_d  = 1'b0;
        if (req_take) begin
            pend_d = sel_req;
        end
        unique case (state_q)
            StOff: begin
                if (req_new) begin
                    state_d = StSwitch;
                end else if (en_req_i) begin
                    state_d = StOn;
                end
            end
            StOn: begin
                if (req_new) begin
                    state_d = StDrain;
                    sw_d    = 1'b1;
                end else if (!en_req_i) begin
                    state_d = StDrain;
                    sw_d    = 1'b0;
                end
            end
            StDrain: begin
                if (cnt_exp) begin
                    if (sw_q) begin
                        state_d = StSwitch;
                    end else begin
                        state_d = StOff;
                        done_d  = 1'b1;
                    end
                end
            end
            StSwitch: begin
                sel_d   = pend_q;
                state_d = StSettle;
            end
            StSettle: begin
                if (cnt_exp) begin
                    state_d = en_req_i ? StOn : StOff;
                    done_d  = 1'b1;
                end
            end
            default: state_d = StOff;
        endcase
        // Same-select request completes immediately without gating.
        if (req_same) begin
            done_d = 1'b1;
        end
    end

    assign en_d     = (state_d == StOn);
    assign cnt_load = (state_d != state_q) && ((state_d == StDrain) || (state_d == StSettle));
    assign cnt_val  = (state_d == StDrain) ? CNT_W'(OFF_CYCLES) : CNT_W'(SETTLE_CYCLES);

    // State and output registers; en_o comes straight from a flop to keep the gate clean.
    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            state_q <= StOff;
            sel_q   <= RST_SELV;
            pend_q  <= RST_SELV;
            sw_q    <= 1'b0;
            en_q    <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            pend_q  <= pend_d;
            sw_q    <= sw_d;
            en_q    <= en_d;
            done_q  <= done_d;
        end
    end

`ifdef CLK_SW_ERR_EN
    // Rejected out-of-range request pulses err_o the cycle after the accept.
    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            err_q <= 1'b0;
        end else begin
            err_q <= accept & sel_oor;
        end
    end
    assign err_o = err_q;
`endif

    clk_sw_cnt #(
        .CNT_W(CNT_W)
    ) u_cnt (
        .clk_i     (clk_i),
        .arst_ni   (arst_ni),
        .load_i    (cnt_load),
        .load_val_i(cnt_val),
        .expire_o  (cnt_exp)
    );

    assign sel_o       = sel_q;
    assign en_o        = en_q;
    assign done_o      = done_q;
    assign sel_ready_o = (state_q == StOff) || (state_q == StOn);
    assign busy_o      = (state_q == StDrain) || (state_q == StSwitch) || (state_q == StSettle);

endmodule

// File: tb/tb_clk_switch_ctrl.sv
// Scoreboarded bench for clk_switch_ctrl; a second 3-source instance covers
// out-of-range select handling (with or without CLK_SW_ERR_EN).
module tb_clk_switch_ctrl;

    logic       clk_i = 1'b0;
    logic       arst_ni;
    logic       en_req_i, sel_valid_i;
    logic [1:0] sel_i;
    logic       sel_ready_o, en_o, busy_o, done_o;
    logic [1:0] sel_o;

    logic       en_req3, sel_valid3;
    logic [1:0] sel3;
    logic       ready3, en3, busy3, done3;
    logic [1:0] sel3_o;
`ifdef CLK_SW_ERR_EN
    logic       err1, err3;
`endif

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;

    typedef struct {
        int         cyc;
        logic [1:0] sel;
        logic       en;
    } exp_t;
    exp_t exp_q[$];

    clk_switch_ctrl u_dut (
        .clk_i      (clk_i),
        .arst_ni    (arst_ni),
        .en_req_i   (en_req_i),
        .sel_valid_i(sel_valid_i),
        .sel_i      (sel_i),
        .sel_ready_o(sel_ready_o),
        .sel_o      (sel_o),
        .en_o       (en_o),
        .busy_o     (busy_o),
        .done_o     (done_o)
`ifdef CLK_SW_ERR_EN
        ,
        .err_o      (err1)
`endif
    );

    clk_switch_ctrl #(
        .NUM_SRC(3)
    ) u_dut3 (
        .clk_i      (clk_i),
        .arst_ni    (arst_ni),
        .en_req_i   (en_req3),
        .sel_valid_i(sel_valid3),
        .sel_i      (sel3),
        .sel_ready_o(ready3),
        .sel_o      (sel3_o),
        .en_o       (en3),
        .busy_o     (busy3),
        .done_o     (done3)
`ifdef CLK_SW_ERR_EN
        ,
        .err_o      (err3)
`endif
    );

    always #5 clk_i = ~clk_i;

    always @(posedge clk_i) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s @cyc %0d: got %0h, expected %0h", name, cyc, act, exp);
        end
    endtask

    task automatic step();
        @(negedge clk_i);
    endtask

    // Monitor: every done_o pulse must match the oldest expected completion.
    always @(negedge clk_i) begin
        if (arst_ni === 1'b1 && done_o === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL done_unexpected @cyc %0d: got done_o=1, expected 0", cyc);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("done_cycle", 32'(cyc), 32'(e.cyc));
                chk("done_sel", 32'(sel_o), 32'(e.sel));
                chk("done_en", 32'(en_o), 32'(e.en));
            end
        end
    end

    initial begin
        int t0;
        arst_ni     = 1'b0;
        en_req_i    = 1'b0;
        sel_valid_i = 1'b0;
        sel_i       = 2'd0;
        en_req3     = 1'b0;
        sel_valid3  = 1'b0;
        sel3        = 2'd0;
        repeat (2) step();
        arst_ni = 1'b1;
        repeat (2) step();

        // Asynchronous reset assertion mid-cycle.
        @(posedge clk_i);
        #3 arst_ni = 1'b0;
        #1;
        chk("rst_sel", 32'(sel_o), 0);
        chk("rst_en", 32'(en_o), 0);
        chk("rst_ready", 32'(sel_ready_o), 1);
        chk("rst_busy", 32'(busy_o), 0);
        chk("rst_done", 32'(done_o), 0);
        en_req_i = 1'b1;
        step();
        arst_ni = 1'b1;
        chk("rel_en_before", 32'(en_o), 0);
        step();
        chk("rel_en_after", 32'(en_o), 1);
        step();

        // Switch 0 -> 2 from ON.
        sel_valid_i = 1'b1;
        sel_i       = 2'd2;
        t0          = cyc;
        chk("sw_ready_t", 32'(sel_ready_o), 1);
        exp_q.push_back('{cyc: t0 + 14, sel: 2'd2, en: 1'b1});
        for (int k = 1; k <= 15; k++) begin
            step();
            if (k == 1) sel_valid_i = 1'b0;
            chk("sw_en", 32'(en_o), 32'(k >= 14));
            chk("sw_busy", 32'(busy_o), 32'(k <= 13));
            chk("sw_ready", 32'(sel_ready_o), 32'(k >= 14));
            chk("sw_sel", 32'(sel_o), (k >= 6) ? 2 : 0);
        end

        // Switch to 1, then same-select request.
        sel_valid_i = 1'b1;
        sel_i       = 2'd1;
        exp_q.push_back('{cyc: cyc + 14, sel: 2'd1, en: 1'b1});
        step();
        sel_valid_i = 1'b0;
        repeat (14) step();
        chk("to1_sel", 32'(sel_o), 1);
        sel_valid_i = 1'b1;
        sel_i       = 2'd1;
        exp_q.push_back('{cyc: cyc + 1, sel: 2'd1, en: 1'b1});
        for (int k = 1; k <= 3; k++) begin
            step();
            if (k == 1) sel_valid_i = 1'b0;
            chk("same_en", 32'(en_o), 1);
            chk("same_busy", 32'(busy_o), 0);
        end

        // Disable-only drain.
        en_req_i = 1'b0;
        exp_q.push_back('{cyc: cyc + 5, sel: 2'd1, en: 1'b0});
        for (int k = 1; k <= 6; k++) begin
            step();
            chk("dis_en", 32'(en_o), 0);
            chk("dis_busy", 32'(busy_o), 32'(k <= 4));
        end

        // Request from OFF: select moves two cycles after accept, gate stays off.
        sel_valid_i = 1'b1;
        sel_i       = 2'd3;
        exp_q.push_back('{cyc: cyc + 10, sel: 2'd3, en: 1'b0});
        for (int k = 1; k <= 11; k++) begin
            step();
            if (k == 1) sel_valid_i = 1'b0;
            chk("off_sel", 32'(sel_o), (k >= 2) ? 3 : 1);
            chk("off_en", 32'(en_o), 0);
        end

        // Simultaneous request and enable fall in ON.
        en_req_i = 1'b1;
        repeat (2) step();
        chk("on_again", 32'(en_o), 1);
        sel_valid_i = 1'b1;
        sel_i       = 2'd0;
        en_req_i    = 1'b0;
        exp_q.push_back('{cyc: cyc + 14, sel: 2'd0, en: 1'b0});
        step();
        sel_valid_i = 1'b0;
        repeat (14) step();
        chk("sim_en", 32'(en_o), 0);
        chk("sim_sel", 32'(sel_o), 0);
        chk("sim_ready", 32'(sel_ready_o), 1);

        // Reset pulse during SETTLE: immediate reset values, no completion.
        en_req_i = 1'b1;
        repeat (2) step();
        sel_valid_i = 1'b1;
        sel_i       = 2'd2;
        step();
        sel_valid_i = 1'b0;
        repeat (7) step();
        chk("mid_busy", 32'(busy_o), 1);
        chk("mid_sel", 32'(sel_o), 2);
        en_req_i = 1'b0;
        #2 arst_ni = 1'b0;
        #1;
        chk("mid_rst_sel", 32'(sel_o), 0);
        chk("mid_rst_busy", 32'(busy_o), 0);
        chk("mid_rst_ready", 32'(sel_ready_o), 1);
        #1 arst_ni = 1'b1;
        repeat (20) step();
        chk("post_rst_sel", 32'(sel_o), 0);
        chk("post_rst_en", 32'(en_o), 0);

        // Out-of-range select on the 3-source instance.
        sel_valid3 = 1'b1;
        sel3       = 2'd3;
        chk("oor_ready", 32'(ready3), 1);
        for (int k = 1; k <= 12; k++) begin
            step();
            if (k == 1) sel_valid3 = 1'b0;
            chk("oor_en", 32'(en3), 0);
`ifdef CLK_SW_ERR_EN
            chk("oor_err", 32'(err3), 32'(k == 1));
            chk("oor_sel", 32'(sel3_o), 0);
            chk("oor_busy", 32'(busy3), 0);
            chk("oor_done", 32'(done3), 0);
`else
            chk("oor_sel", 32'(sel3_o), (k >= 2) ? 2 : 0);
            chk("oor_busy", 32'(busy3), 32'(k <= 9));
            chk("oor_done", 32'(done3), 32'(k == 10));
`endif
        end

        chk("sb_drained", 32'(exp_q.size()), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/clk_switch_ctrl.md
Name: clk_switch_ctrl

Overview:
- Sequencer for the 4-input clock mux and output clock gate; drives their select and enable inputs.
- Performs a glitch-free source change: gate off, drain, switch select, settle, gate back on.
- Runs on an always-on reference clock, independent of the PLL sources being switched.
- Accepts source-change requests through a valid/ready handshake and a level enable request.

Parameters:
- NUM_SRC, 4, number of selectable clock sources (2..4).
- SEL_W, 2, select width; equals $clog2(NUM_SRC) for NUM_SRC ≥ 2.
- OFF_CYCLES, 4, cycles en_o is held low before the select changes (≥1).
- SETTLE_CYCLES, 8, cycles after the select changes before en_o may rise (≥1).
- RST_SEL, 0, sel_o value after reset.

Ports:
- clk_i  input  1  always-on reference clock.
- arst_ni  input  1  asynchronous active-low reset.
- en_req_i  input  1  level request: 1 = gated clock output wanted on.
- sel_valid_i  input  1  source-change request valid.
- sel_i  input  SEL_W  requested source index.
- sel_ready_o  output  1  request accepted when sel_valid_i && sel_ready_o at a clk_i edge.
- sel_o  output  SEL_W  registered select to the clock mux.
- en_o  output  1  registered enable to the clock gate.
- busy_o  output  1  high in DRAIN, SWITCH and SETTLE.
- done_o  output  1  one-cycle pulse on sequence completion.

Behaviour:
- Reset values (asynchronous): state OFF, sel_o = RST_SEL, en_o = 0, sel_ready_o = 1, busy_o = 0, done_o = 0, counters = 0, pending select = RST_SEL.
- States: OFF, ON, DRAIN, SWITCH, SETTLE. en_o = 1 only in ON. sel_ready_o = 1 only in OFF and ON.
- On accept, sel_i is captured into the pending register.
- OFF:
  - Accept with new select → SWITCH.
  - Else en_req_i = 1 → ON.
  - Else stay in OFF.
- ON:
  - Accept with new select → DRAIN, flagged as a switch.
  - Else en_req_i = 0 → DRAIN, flagged as disable-only.
- DRAIN:
  - Lasts exactly OFF_CYCLES cycles; the counter is loaded on entry.
  - Switch flag set → SWITCH. Otherwise → OFF.
- SWITCH:
  - Lasts one cycle; sel_o loads the pending value at its closing edge.
  - → SETTLE.
- SETTLE:
  - Lasts exactly SETTLE_CYCLES cycles.
  - Then en_req_i sampled: 1 → ON, 0 → OFF.
- Same-select request (sel_i == sel_o) in OFF or ON: accepted; no state change and no gating; done_o pulses the next cycle.
- done_o timing: pulses in the first cycle of ON/OFF after SETTLE, and the first cycle of OFF after a disable-only DRAIN.
- Timing from ON, accept at cycle T:
  - en_o = 0 from T+1.
  - New sel_o from T+OFF_CYCLES+2.
  - en_o = 1 and done_o at T+OFF_CYCLES+SETTLE_CYCLES+2.
- en_req_i changes during DRAIN, SWITCH or SETTLE are ignored; it is sampled only at sequence end.
- Simultaneous sel_valid_i and en_req_i fall in ON: the switch is performed; the block ends in OFF.
- Reset mid-sequence: returns to reset values immediately. The pending request is lost; no done_o.
- Counter width: $clog2(max(OFF_CYCLES, SETTLE_CYCLES)+1). The counter counts down; expiry at 1.

Optional Feature:
- Macro: CLK_SW_ERR_EN.
- Defined:
  - Adds port err_o (output, 1 bit).
  - A request with sel_i ≥ NUM_SRC is accepted and discarded: no state change, sel_o unchanged, no done_o.
  - err_o pulses one cycle after the accept.
- Undefined:
  - No err_o port.
  - Out-of-range sel_i is clamped to NUM_SRC-1 and processed normally.

Decomposition:
- Package clk_sw_pkg: state enum typedef clk_sw_state_e (OFF, ON, DRAIN, SWITCH, SETTLE); default constants for OFF_CYCLES, SETTLE_CYCLES and RST_SEL.
- One sub-module, clk_sw_cnt: a loadable down-counter with an expire flag, instantiated once and reused for DRAIN and SETTLE.

Test Plan:
- Reset: drop arst_ni asynchronously → sel_o=0, en_o=0, sel_ready_o=1, busy_o=0; hold en_req_i=1, then release reset → en_o=1 one cycle after the first edge.
- Defaults, ON, request sel_i=2 accepted at T:
  - en_o=0 from T+1; sel_o=2 from T+6.
  - en_o=1 and done_o at T+14.
  - busy_o high T+1..T+13; sel_ready_o low throughout.
- Same select: ON with sel_o=1, request sel_i=1 → en_o stays 1, done_o pulses at T+1, busy_o stays 0.
- Disable then request in OFF:
  - en_req_i 1→0 → en_o=0 next cycle; OFF after 4 drain cycles with done_o.
  - Request sel_i=3 → sel_o=3 two cycles after the accept; en_o stays 0 (en_req_i=0).
- Simultaneous and mid-sequence:
  - Accept plus en_req_i fall in ON → ends in OFF with sel_o updated.
  - Separately, pulse arst_ni during SETTLE → immediate reset values; no done_o.
- With CLK_SW_ERR_EN and NUM_SRC=3: request sel_i=3 → err_o pulses at T+1, sel_o and en_o unchanged. Without the macro → switches to sel_o=2.
